seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have a parameter NUM_DIGITS, default 4, giving the number of multiplexed digit positions observed.
REQ-002 The block SHALL have a parameter STABLE_CYCLES, default 8, range 2..255, giving the consecutive identical samples required before a capture.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port an, input, NUM_DIGITS bits: digit enables, active-high; bit i selects position i.
REQ-006 The block SHALL have port seg, input, 7 bits: segment lines {a,b,c,d,e,f,g}, active-high, a = MSB.
REQ-007 The block SHALL have port digits, output, 4*NUM_DIGITS bits: the decoded code for position i in bits [4i+3:4i].
REQ-008 The block SHALL have port digit_valid, output, NUM_DIGITS bits: sticky; bit i set once position i has been captured since reset.
REQ-009 The block SHALL have port bad_code, output, NUM_DIGITS bits: bit i high while position i's last capture was an illegal pattern.
REQ-010 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when every position has been captured in the current frame.
REQ-011 The block SHALL have port anode_err, output, 1 bit: a one-cycle pulse when a stable multi-hot an is detected.

Function
REQ-012 The block SHALL register an and seg in one input stage; all comparisons use the registered copies.
REQ-013 The block SHALL keep a stability counter: it increments, saturating at STABLE_CYCLES, while the registered {an,seg} equals its previous value; on any difference it reloads to 1.
REQ-014 A capture event SHALL occur only on the edge where the counter first reaches STABLE_CYCLES: once per dwell, with no repeat while saturated.
REQ-015 On a capture with one-hot an selecting position i, the block SHALL write the decoded code to digits slot i, set digit_valid[i] and the internal frame-mask bit i, and update bad_code[i].
REQ-016 The decoding SHALL map 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8 and 7B->9 (hex seg values); 00 (blank) SHALL map to 4'hF with bad_code=0.
REQ-017 Any other seg pattern SHALL decode to 4'hE and set bad_code[i]=1.
REQ-018 Capture latency: with {an,seg} held at the inputs, digits SHALL update on the (STABLE_CYCLES+1)-th rising edge after the value first appears; for the default, that is the 9th edge.
REQ-019 A capture with an == 0 SHALL have no effect: no write, no error.
REQ-020 A capture with more than one an bit set SHALL write nothing and SHALL pulse anode_err high for exactly the cycle following the capture edge.
REQ-021 When a capture makes the frame mask all-ones, frame_done SHALL pulse high for exactly the cycle following that capture edge, and the frame mask SHALL clear on the same edge.
REQ-022 Recapture of an already-masked position before frame completion SHALL overwrite digits and bad_code for that position and leave the mask unchanged.
REQ-023 A change of an or seg before the counter reaches STABLE_CYCLES SHALL discard the partial dwell, producing no capture.

Reset
REQ-024 While rst is high at a rising edge, the block SHALL drive digits, digit_valid, bad_code, frame_done and anode_err to 0, and clear the input stage, counter and frame mask.
REQ-025 Reset asserted mid-dwell or mid-frame SHALL abandon the partial dwell and frame; after reset, an input already stable SHALL still need a full STABLE_CYCLES+1 edges to capture.

Verification
REQ-026 Hold an=0001, seg=7'h6D for 20 cycles -> digits[3:0]=2 on the 9th edge; digit_valid=0001; exactly one capture; frame_done stays 0.
REQ-027 Scan an=0001/0010/0100/1000 with 7E/30/79/7B, 10 cycles each -> digits=16'h9310; frame_done pulses once, 1 cycle after the 4th capture; bad_code=0.
REQ-028 Hold an=0010, seg=7'h49 for 10 cycles -> digits[7:4]=E and bad_code[1]=1; then hold 7'h00 -> digits[7:4]=F and bad_code[1]=0.
REQ-029 Hold an=0011 for 10 cycles -> anode_err pulses once and no slot changes; alternate seg every 5 cycles -> no capture ever.
REQ-030 Assert rst at cycle 5 of an 8-cycle dwell -> all outputs 0; with inputs still held, capture occurs 9 edges after rst deasserts.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder_if
//  Description : Bundle carrying the scanned 7-segment display lines into the
//                decoder and the decoded digit/status results back out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   bad_code;
    logic                    frame_done;
    logic                    anode_err;

    // Display side: drives the scan lines, observes the decoded results.
    modport master (
        output an,
        output seg,
        input  digits,
        input  digit_valid,
        input  bad_code,
        input  frame_done,
        input  anode_err
    );

    // Decoder side.
    modport slave (
        input  an,
        input  seg,
        output digits,
        output digit_valid,
        output bad_code,
        output frame_done,
        output anode_err
    );

endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Watches a multiplexed 7-segment display bus, waits for each
//                {an,seg} combination to dwell for STABLE_CYCLES samples and
//                then decodes the segment pattern into the digit slot that
//                the one-hot anode selects.  Reports illegal patterns,
//                multi-hot anodes and completion of a full scan frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input wire                clk,
    input wire                rst,
    seg_scan_decoder_if.slave bus
);

    localparam logic [7:0]            c_stable    = 8'(STABLE_CYCLES);
    localparam logic [7:0]            c_stable_m1 = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one    = NUM_DIGITS'(1);

    // Input stage and its one-sample history
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an_prev;
    logic [6:0]              r_seg_prev;

    // Dwell counter, saturates at c_stable
    logic [7:0]              r_cnt;

    // Captured results and frame tracking
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_bad;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic                    r_frame_done;
    logic                    r_anode_err;

    logic                    w_same;
    logic                    w_capture;
    logic                    w_an_nz;
    logic                    w_an_onehot;
    logic                    w_an_multi;
    logic [NUM_DIGITS-1:0]   w_wr;
    logic [NUM_DIGITS-1:0]   w_mask_upd;
    logic                    w_frame_full;
    logic [3:0]              w_code;
    logic                    w_bad;

    // The comparison is done entirely on registered copies so that an
    // asynchronous display bus never feeds the compare logic directly.
    assign w_same      = (r_an == r_an_prev) && (r_seg == r_seg_prev);
    // Fires only on the transition into saturation, so a long dwell
    // produces a single capture.
    assign w_capture   = w_same && (r_cnt == c_stable_m1);
    assign w_an_nz     = |r_an;
    assign w_an_onehot = w_an_nz && ((r_an & (r_an - c_an_one)) == '0);
    assign w_an_multi  = w_an_nz && !w_an_onehot;
    assign w_wr        = (w_capture && w_an_onehot) ? r_an : '0;
    assign w_mask_upd  = r_mask | w_wr;
    assign w_frame_full = (|w_wr) && (&w_mask_upd);

    // Segment pattern {a..g} to BCD code; blank is F, anything else is E.
    always_comb begin
        w_code = 4'hE;
        w_bad  = 1'b1;
        case (r_seg)
            7'h7E: begin w_code = 4'h0; w_bad = 1'b0; end
            7'h30: begin w_code = 4'h1; w_bad = 1'b0; end
            7'h6D: begin w_code = 4'h2; w_bad = 1'b0; end
            7'h79: begin w_code = 4'h3; w_bad = 1'b0; end
            7'h33: begin w_code = 4'h4; w_bad = 1'b0; end
            7'h5B: begin w_code = 4'h5; w_bad = 1'b0; end
            7'h5F: begin w_code = 4'h6; w_bad = 1'b0; end
            7'h70: begin w_code = 4'h7; w_bad = 1'b0; end
            7'h7F: begin w_code = 4'h8; w_bad = 1'b0; end
            7'h7B: begin w_code = 4'h9; w_bad = 1'b0; end
            7'h00: begin w_code = 4'hF; w_bad = 1'b0; end
            default: begin w_code = 4'hE; w_bad = 1'b1; end
        endcase
    end

    // Register the display bus and keep the previous sample for comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an       <= '0;
            r_seg      <= '0;
            r_an_prev  <= '0;
            r_seg_prev <= '0;
        end else begin
            r_an       <= bus.an;
            r_seg      <= bus.seg;
            r_an_prev  <= r_an;
            r_seg_prev <= r_seg;
        end
    end

    // Count consecutive identical samples; any change restarts the dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_same) begin
            r_cnt <= 8'd1;
        end else if (r_cnt != c_stable) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Write the decoded code into the slot selected by a one-hot capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_bad    <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr[i]) begin
                    r_digits[4*i +: 4] <= w_code;
                    r_bad[i]           <= w_bad;
                    r_valid[i]         <= 1'b1;
                end
            end
        end
    end

    // Track which slots have been seen this frame and raise the status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask       <= '0;
            r_frame_done <= 1'b0;
            r_anode_err  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_full;
            r_anode_err  <= w_capture && w_an_multi;
            r_mask       <= w_frame_full ? '0 : w_mask_upd;
        end
    end

    assign bus.digits      = r_digits;
    assign bus.digit_valid = r_valid;
    assign bus.bad_code    = r_bad;
    assign bus.frame_done  = r_frame_done;
    assign bus.anode_err   = r_anode_err;

endmodule
`default_nettype wire
